// File: rtl/sram_access_ctrl.sv
// SRAM access controller: sweeps every row with INIT_VALUE after reset or clear,
// then shares the single SRAM port between two requesters with round-robin arbitration.
module sram_access_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    HEIGHT     = 128,
    parameter int                    ADDR_BITS  = 7,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  clear,
    output logic                  init_done,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_BITS-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_mem_en,
    output logic                  sram_mem_write_en,
    input  logic [DATA_WIDTH-1:0] sram_data_out
);

    typedef enum logic {
        ST_INIT,
        ST_ARB
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(HEIGHT - 1);

    state_t               state;
    logic [ADDR_BITS-1:0] init_cnt;
    logic                 last_gnt;
    logic                 arb_live;

    // Arbitration only runs once the sweep is done, and a clear cycle issues no grant.
    assign arb_live = rst_b && (state == ST_ARB) && !clear;

    // The SRAM registers its read data, so the shared bus is already aligned with rvalid.
    assign rdata = sram_data_out;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_live) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        sram_mem_en       = 1'b0;
        sram_mem_write_en = 1'b0;
        sram_addr         = '0;
        sram_data_in      = '0;
        if (rst_b) begin
            if (state == ST_INIT) begin
                sram_mem_en       = 1'b1;
                sram_mem_write_en = 1'b1;
                sram_addr         = init_cnt;
                sram_data_in      = INIT_VALUE;
            end else if (gnt0) begin
                sram_mem_en       = 1'b1;
                sram_mem_write_en = wr0;
                sram_addr         = addr0;
                sram_data_in      = wdata0;
            end else if (gnt1) begin
                sram_mem_en       = 1'b1;
                sram_mem_write_en = wr1;
                sram_addr         = addr1;
                sram_data_in      = wdata1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            last_gnt  <= 1'b1;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == LAST_ROW) begin
                        state     <= ST_ARB;
                        init_done <= 1'b1;
                        init_cnt  <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (clear) begin
                        state     <= ST_INIT;
                        init_done <= 1'b0;
                        init_cnt  <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase

            if (gnt0) begin
                last_gnt <= 1'b0;
            end else if (gnt1) begin
                last_gnt <= 1'b1;
            end

            // A read returns one cycle after its grant; writes and idle cycles yield nothing.
            rvalid0 <= gnt0 && !wr0;
            rvalid1 <= gnt1 && !wr1;
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 1-cycle-latency SRAM attached.
`timescale 1ns/1ps
module tb_sram_access_ctrl;

    localparam int              DW   = 16;
    localparam int              H    = 128;
    localparam int              AB   = 7;
    localparam logic [DW-1:0]   INIT = 16'h00AA;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          clear = 1'b0;
    logic          init_done;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AB-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AB-1:0] sram_addr;
    logic [DW-1:0] sram_data_in;
    logic          sram_mem_en, sram_mem_write_en;
    logic [DW-1:0] sram_data_out = '0;

    logic [DW-1:0] mem [0:H-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_access_ctrl #(
        .DATA_WIDTH(DW),
        .HEIGHT    (H),
        .ADDR_BITS (AB),
        .INIT_VALUE(INIT)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .clear            (clear),
        .init_done        (init_done),
        .req0             (req0),
        .req1             (req1),
        .wr0              (wr0),
        .wr1              (wr1),
        .addr0            (addr0),
        .addr1            (addr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .rvalid0          (rvalid0),
        .rvalid1          (rvalid1),
        .rdata            (rdata),
        .sram_addr        (sram_addr),
        .sram_data_in     (sram_data_in),
        .sram_mem_en      (sram_mem_en),
        .sram_mem_write_en(sram_mem_write_en),
        .sram_data_out    (sram_data_out)
    );

    // Behavioural SRAM: synchronous write, registered read with latency 1.
    always @(posedge clk) begin
        if (sram_mem_en) begin
            if (sram_mem_write_en) mem[sram_addr] <= sram_data_in;
            else                   sram_data_out  <= mem[sram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in sweep cycle 0; checks H sweep writes then init_done on the H-th edge.
    task automatic run_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            if (!(sram_mem_en === 1'b1 && sram_mem_write_en === 1'b1 &&
                  sram_addr === AB'(i) && sram_data_in === INIT &&
                  gnt0 === 1'b0 && gnt1 === 1'b0 && init_done === 1'b0)) begin
                if (bad == 0)
                    $display("FAIL %s sweep cycle %0d: en=%b we=%b addr=%0d din=%h gnt=%b%b done=%b, required addr=%0d din=%h en=we=1 gnt=00 done=0",
                             tag, i, sram_mem_en, sram_mem_write_en, sram_addr, sram_data_in,
                             gnt1, gnt0, init_done, i, INIT);
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL %s sweep: %0d bad cycles, required 0", tag, bad);
            n_fail++;
        end
        next_cycle();
        n_checks++;
        if (init_done !== 1'b1) begin
            $display("FAIL %s init_done after %0d edges: got %b required 1", tag, H, init_done);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'd3;
        #2;
        n_checks++;
        if ({sram_mem_en, sram_mem_write_en, sram_addr, sram_data_in, gnt0, gnt1} !== '0) begin
            $display("FAIL reset_outputs: en=%b we=%b addr=%0d din=%h gnt=%b%b required all 0",
                     sram_mem_en, sram_mem_write_en, sram_addr, sram_data_in, gnt1, gnt0);
            n_fail++;
        end
        n_checks++;
        if ({init_done, rvalid0, rvalid1} !== 3'b000) begin
            $display("FAIL reset_flags: done=%b rv0=%b rv1=%b required 000", init_done, rvalid0, rvalid1);
            n_fail++;
        end
        next_cycle();
        next_cycle();
        rst_b = 1'b1;
        run_sweep("power_on");
        // req0 held through the sweep, read of never-written addr 3.
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sram_addr !== 7'd3 || sram_mem_write_en !== 1'b0) begin
            $display("FAIL held_req0_grant: gnt=%b%b addr=%0d we=%b required gnt=01 addr=3 we=0",
                     gnt1, gnt0, sram_addr, sram_mem_write_en);
            n_fail++;
        end
        next_cycle();
        req0 = 1'b0;
        n_checks++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== INIT) begin
            $display("FAIL unwritten_read: rv=%b%b rdata=%h required rv=01 rdata=%h",
                     rvalid1, rvalid0, rdata, INIT);
            n_fail++;
        end
        next_cycle();
        n_checks++;
        if (rvalid0 !== 1'b0) begin
            $display("FAIL rvalid_one_cycle: rvalid0=%b required 0", rvalid0);
            n_fail++;
        end
    endtask

    task automatic test_write_then_read();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 7'd5; wdata0 = 16'h1234;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sram_mem_en !== 1'b1 || sram_mem_write_en !== 1'b1 ||
            sram_addr !== 7'd5 || sram_data_in !== 16'h1234) begin
            $display("FAIL write_issue: gnt=%b%b en=%b we=%b addr=%0d din=%h required gnt=01 en=1 we=1 addr=5 din=1234",
                     gnt1, gnt0, sram_mem_en, sram_mem_write_en, sram_addr, sram_data_in);
            n_fail++;
        end
        next_cycle();
        req0 = 1'b0; wr0 = 1'b0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'd5;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 ||
            sram_addr !== 7'd5 || sram_mem_write_en !== 1'b0) begin
            $display("FAIL read_issue: gnt=%b%b rv=%b%b addr=%0d we=%b required gnt=10 rv=00 addr=5 we=0",
                     gnt1, gnt0, rvalid1, rvalid0, sram_addr, sram_mem_write_en);
            n_fail++;
        end
        next_cycle();
        req1 = 1'b0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 16'h1234) begin
            $display("FAIL write_read_data: rv=%b%b rdata=%h required rv=10 rdata=1234",
                     rvalid1, rvalid0, rdata);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (sram_mem_en !== 1'b0 || sram_addr !== '0 || sram_data_in !== '0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            $display("FAIL idle_bus: en=%b addr=%0d din=%h gnt=%b%b required all 0",
                     sram_mem_en, sram_addr, sram_data_in, gnt1, gnt0);
            n_fail++;
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]    exp_gnt0  = 6'b010101; // bit k = gnt0 in cycle k
        logic [DW-1:0] exp_data;
        // Mark addr 2 so the two streams return distinguishable data.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 7'd2; wdata1 = 16'hBEEF;
        next_cycle();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'd1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (gnt0 !== exp_gnt0[k] || gnt1 !== !exp_gnt0[k]) begin
                $display("FAIL rr_grant[%0d]: gnt=%b%b required gnt0=%b gnt1=%b",
                         k, gnt1, gnt0, exp_gnt0[k], !exp_gnt0[k]);
                n_fail++;
            end
            if (k > 0) begin
                exp_data = exp_gnt0[k-1] ? INIT : 16'hBEEF;
                n_checks++;
                if (rvalid0 !== exp_gnt0[k-1] || rvalid1 !== !exp_gnt0[k-1] || rdata !== exp_data) begin
                    $display("FAIL rr_rdata[%0d]: rv=%b%b rdata=%h required rv0=%b rv1=%b rdata=%h",
                             k, rvalid1, rvalid0, rdata, exp_gnt0[k-1], !exp_gnt0[k-1], exp_data);
                    n_fail++;
                end
            end
            next_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 16'hBEEF) begin
            $display("FAIL rr_last_rdata: rv=%b%b rdata=%h required rv=10 rdata=beef", rvalid1, rvalid0, rdata);
            n_fail++;
        end
        next_cycle();
    endtask

    task automatic test_clear();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'd5;
        next_cycle();
        req0 = 1'b0;
        clear = 1'b1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'd2;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || sram_mem_en !== 1'b0 || rvalid0 !== 1'b1 ||
            rdata !== 16'h1234 || init_done !== 1'b1) begin
            $display("FAIL clear_cycle: gnt=%b%b en=%b rv0=%b rdata=%h done=%b required gnt=00 en=0 rv0=1 rdata=1234 done=1",
                     gnt1, gnt0, sram_mem_en, rvalid0, rdata, init_done);
            n_fail++;
        end
        next_cycle();
        clear = 1'b0;
        n_checks++;
        if (init_done !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            $display("FAIL clear_enters_init: done=%b rv=%b%b required done=0 rv=00", init_done, rvalid1, rvalid0);
            n_fail++;
        end
        run_sweep("clear");
        // Pending req1 read of addr 2 (was BEEF) is served after the sweep.
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            $display("FAIL pending_after_clear: gnt=%b%b required 10", gnt1, gnt0);
            n_fail++;
        end
        next_cycle();
        req1 = 1'b0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rdata !== INIT) begin
            $display("FAIL reinit_addr2: rv1=%b rdata=%h required rv1=1 rdata=%h", rvalid1, rdata, INIT);
            n_fail++;
        end
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'd5;
        next_cycle();
        req0 = 1'b0;
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata !== INIT) begin
            $display("FAIL reinit_addr5: rv0=%b rdata=%h required rv0=1 rdata=%h", rvalid0, rdata, INIT);
            n_fail++;
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_sweep();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        repeat (40) next_cycle();
        n_checks++;
        if (sram_addr !== 7'd40 || sram_mem_en !== 1'b1) begin
            $display("FAIL mid_sweep_pos: addr=%0d en=%b required addr=40 en=1", sram_addr, sram_mem_en);
            n_fail++;
        end
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (sram_mem_en !== 1'b0 || sram_mem_write_en !== 1'b0 || sram_addr !== '0 || init_done !== 1'b0) begin
            $display("FAIL async_reset: en=%b we=%b addr=%0d done=%b required all 0",
                     sram_mem_en, sram_mem_write_en, sram_addr, init_done);
            n_fail++;
        end
        next_cycle();
        rst_b = 1'b1;
        run_sweep("after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_then_read();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Controller in front of one sram_model bank (16b x 128 default).
- After reset, or on command, it sweeps every row with INIT_VALUE, so the bank has defined contents without a memory-init file.
- It then shares the single SRAM port between two requesters (e.g. Q-value update engine and action-select reader) with round-robin arbitration.
- It routes registered read data back to the requester that issued the read.

Parameters:
DATA_WIDTH, 16, SRAM word width
HEIGHT, 128, number of SRAM rows
ADDR_BITS, 7, SRAM address width; HEIGHT <= 2**ADDR_BITS
INIT_VALUE, 0, word written to every row during the init sweep

Ports:
clk  in  1  clock; all logic on rising edge
rst_b  in  1  asynchronous active-low reset
clear  in  1  pulse: restart the init sweep (honoured only in ARB)
init_done  out  1  high once the sweep has finished and arbitration is live
req0 / req1  in  1  access request; held high until the matching gnt
wr0 / wr1  in  1  1 = write, 0 = read; qualified by req
addr0 / addr1  in  ADDR_BITS  request address
wdata0 / wdata1  in  DATA_WIDTH  write data
gnt0 / gnt1  out  1  combinational one-cycle grant; the access is issued this cycle
rvalid0 / rvalid1  out  1  registered; read data valid for that requester
rdata  out  DATA_WIDTH  shared read data = sram_data_out; qualified by rvalid0/1
sram_addr  out  ADDR_BITS  to sram_model addr
sram_data_in  out  DATA_WIDTH  to sram_model data_in
sram_mem_en  out  1  to sram_model mem_en
sram_mem_write_en  out  1  to sram_model mem_write_en
sram_data_out  in  DATA_WIDTH  from sram_model data_out

Behaviour:
Reset (rst_b low, asynchronous):
- state=INIT, init_cnt=0, init_done=0, rvalid0/1=0, last_gnt=1 (so req0 wins the first tie).
- While rst_b is low, all sram_* outputs are 0 and gnt0/1 are 0.

State INIT:
- Each cycle drives sram_mem_en=1, sram_mem_write_en=1, sram_addr=init_cnt, sram_data_in=INIT_VALUE; init_cnt increments.
- When init_cnt==HEIGHT-1 is written, next state is ARB, init_done=1 and init_cnt returns to 0.
- The sweep takes exactly HEIGHT cycles.
- gnt0/1=0 throughout; requests simply wait.
- clear is ignored in INIT.

State ARB:
- Grant is combinational from req0/req1 and last_gnt:
  - only one requester active: it is granted;
  - both active: the requester that is not last_gnt is granted.
- The granted requester's addr/wdata/wr drive the SRAM in the same cycle with sram_mem_en=1 and sram_mem_write_en=wr.
- No grant: sram_mem_en=0, sram_mem_write_en=0, sram_addr=0, sram_data_in=0.
- last_gnt updates on every grant.
- A granted read sets rvalid<n>=1 on the next edge, for one cycle. The SRAM read latency is 1, so rdata is valid in that same cycle.
- A granted write produces no rvalid.
- Write followed by a read of the same address on the next cycle returns the new data.
- Throughput: one access per cycle, back-to-back. Under continuous contention the grants alternate 0,1,0,1.
- clear=1 in ARB: no grant is issued in that cycle. Next state is INIT and init_done goes 0 on that edge.
  - An rvalid already scheduled from the previous cycle is still delivered.
  - Held requests stay pending until the sweep completes.

Invariants:
- At most one gnt is asserted per cycle.
- At most one rvalid is asserted per cycle.
- rvalid never asserts in a cycle after a write or an idle cycle.
- Async reset mid-sweep or mid-read aborts everything: rvalid clears immediately and the sweep restarts from address 0 after release.

Test Plan:
- Reset then release, INIT_VALUE=16'h00AA, HEIGHT=128 -> exactly 128 write strobes at addresses 0..127; init_done rises on the 128th edge; req0 held during the sweep gets gnt0 only after init_done.
- req0 write addr 5 data 16'h1234; next cycle req1 read addr 5 -> gnt1 in that cycle, rvalid1=1 one cycle later with rdata=16'h1234, rvalid0 stays 0.
- req0 and req1 both held high with reads of addr 1 and addr 2 for 6 cycles after init -> gnt sequence 0,1,0,1,0,1; each read's data arrives one cycle after its grant on the matching rvalid.
- Read of an address never written after init -> rdata=INIT_VALUE with rvalid asserted.
- Read granted in cycle N, clear in cycle N+1 -> rvalid still asserted in N+1, no grant in N+1, init_done=0 from N+2, new 128-cycle sweep, then a prior write at addr 5 reads back INIT_VALUE.
- rst_b asserted mid-sweep at init_cnt=40 -> sram_mem_en=0 immediately; after release the sweep restarts at address 0 and init_done takes a full 128 cycles.
